// File: rtl/nv_ram_rws_64x1088_fifo_ctrl_pkg.sv
// Shared constants and types for the 64x1088 RAM FIFO controller.
//   DEPTH      : RAM entries (must match the attached RAM)
//   AW         : RAM address width, log2(DEPTH)
//   DW         : payload / RAM data width
//   SKID_DEPTH : entries in the output capture buffer
//   ptr_t      : AW+1 bit pointer; the extra MSB is the wrap bit
package nv_ram_rws_64x1088_fifo_ctrl_pkg;

  localparam int DEPTH      = 64;
  localparam int AW         = 6;
  localparam int DW         = 1088;
  localparam int SKID_DEPTH = 2;

  typedef logic [AW:0] ptr_t;

endpackage

// File: rtl/nv_ram_fifo_skid2.sv
// Two-entry capture/pop buffer sitting behind the RAM read port.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   cap_i         : write cap_data_i into the tail this cycle
//   cap_data_i    : data returned by the RAM
//   pop_i         : head consumed this cycle (only asserted when cnt_o != 0)
//   cnt_o         : entries currently held (0..2)
//   cnt_nxt_o     : entry count after this cycle's capture/pop
//   head_o        : oldest entry; stable until popped
// Capture and pop may happen in the same cycle.
module nv_ram_fifo_skid2
  import nv_ram_rws_64x1088_fifo_ctrl_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cap_i,
  input  logic [DW-1:0] cap_data_i,
  input  logic          pop_i,
  output logic [1:0]    cnt_o,
  output logic [1:0]    cnt_nxt_o,
  output logic [DW-1:0] head_o
);

  logic [DW-1:0] mem_q [SKID_DEPTH];
  logic          hd_q, hd_d;
  logic          tl_q, tl_d;
  logic [1:0]    cnt_q, cnt_d;

  always_comb begin
    hd_d  = hd_q ^ pop_i;
    tl_d  = tl_q ^ cap_i;
    cnt_d = cnt_q + {1'b0, cap_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hd_q  <= 1'b0;
      tl_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      hd_q  <= hd_d;
      tl_q  <= tl_d;
      cnt_q <= cnt_d;
    end
  end

  // Data storage needs no reset: cnt_q qualifies every entry.
  always_ff @(posedge clk_i) begin
    if (cap_i) mem_q[tl_q] <= cap_data_i;
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign head_o    = mem_q[hd_q];

endmodule

// File: rtl/nv_ram_rws_64x1088_fifo_ctrl.sv
// FIFO controller wrapped around the 64x1088 two-port RAM (registered read
// address, combinational read data). Owns write/issue/free pointers, the
// one-cycle read-latency flag and the output skid buffer.
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock, asynchronous active-low reset
//   in_pvld/in_prdy/in_pd           : input payload handshake
//   out_pvld/out_prdy/out_pd        : output payload handshake (skid head)
//   ram_we/ram_wa/ram_di            : RAM write port
//   ram_re/ram_ra/ram_dout          : RAM read port, data valid cycle after ram_re
//   fifo_count                      : entries held (RAM-occupied + skid)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holds valid and data until the transfer; ready may change
// freely. out_pd is held stable while out_pvld & ~out_prdy.
module nv_ram_rws_64x1088_fifo_ctrl
  import nv_ram_rws_64x1088_fifo_ctrl_pkg::*;
(
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          in_pvld,
  output logic          in_prdy,
  input  logic [DW-1:0] in_pd,
  output logic          out_pvld,
  input  logic          out_prdy,
  output logic [DW-1:0] out_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   fifo_count
);

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        iss_ptr_q, iss_ptr_d;
  ptr_t        free_ptr_q, free_ptr_d;
  ptr_t        ram_used;
  logic        rdy_en_q;
  logic        rd_inflight_q;
  logic        push, pop, cap;
  logic [1:0]  skid_cnt, skid_cnt_nxt;
  logic [2:0]  skid_load;
  logic [AW:0] fifo_count_q, fifo_count_d;

  // Slots stay occupied until their data is captured, so a write can never
  // overwrite the address the RAM is still presenting on ram_dout.
  assign ram_used = wr_ptr_q - free_ptr_q;
  assign in_prdy  = rdy_en_q & (ram_used != ptr_t'(DEPTH));
  assign push     = in_pvld & in_prdy;
  assign pop      = out_pvld & out_prdy;
  assign cap      = rd_inflight_q;

  // Issue only if the skid can absorb the read after this cycle's pop:
  // entries held plus the read already in flight must leave a free slot.
  assign skid_load = {1'b0, skid_cnt} + {2'b0, rd_inflight_q} - {2'b0, pop};
  assign ram_re    = (wr_ptr_q != iss_ptr_q) & (skid_load < 3'(SKID_DEPTH));

  assign ram_we   = push;
  assign ram_wa   = wr_ptr_q[AW-1:0];
  assign ram_di   = in_pd;
  assign ram_ra   = iss_ptr_q[AW-1:0];
  assign out_pvld = (skid_cnt != 2'd0);

  always_comb begin
    wr_ptr_d     = wr_ptr_q   + ptr_t'(push);
    iss_ptr_d    = iss_ptr_q  + ptr_t'(ram_re);
    free_ptr_d   = free_ptr_q + ptr_t'(cap);
    fifo_count_d = (wr_ptr_d - free_ptr_d) + ptr_t'(skid_cnt_nxt);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q      <= '0;
      iss_ptr_q     <= '0;
      free_ptr_q    <= '0;
      rdy_en_q      <= 1'b0;
      rd_inflight_q <= 1'b0;
      fifo_count_q  <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      iss_ptr_q     <= iss_ptr_d;
      free_ptr_q    <= free_ptr_d;
      rdy_en_q      <= 1'b1;
      rd_inflight_q <= ram_re;
      fifo_count_q  <= fifo_count_d;
    end
  end

  assign fifo_count = fifo_count_q;

  nv_ram_fifo_skid2 u_skid (
    .clk_i      (nvdla_core_clk),
    .rst_ni     (nvdla_core_rstn),
    .cap_i      (cap),
    .cap_data_i (ram_dout),
    .pop_i      (pop),
    .cnt_o      (skid_cnt),
    .cnt_nxt_o  (skid_cnt_nxt),
    .head_o     (out_pd)
  );

endmodule
